apb_master_arbiter: RTL and testbench

- Multi-requester APB master: round-robin arbitration between NREQ local requesters and sequencing of the single shared APB bus through SETUP/ACCESS phases.
- Drives the master side of the APB interface: PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB.
- Returns read data and error status to the owning requester.
- Includes a PREADY watchdog so a hung slave cannot lock the bus.

---
 rtl/apb_master_arbiter.sv | 163 ++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter in front of a single APB master port.
// One transfer in flight; a PREADY watchdog aborts hung ACCESS phases.
module apb_master_arbiter #(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TCW            = 9
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ*32-1:0]   req_addr,
  input  logic [NREQ*32-1:0]   req_wdata,
  input  logic [NREQ*4-1:0]    req_strb,
  input  logic [NREQ*3-1:0]    req_prot,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_slverr,
  output logic                 rsp_timeout,
  output logic [31:0]          PADDR,
  output logic [2:0]           PPROT,
  output logic                 PSEL,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [31:0]          PWDATA,
  output logic [3:0]           PSTRB,
  input  logic                 PREADY,
  input  logic [31:0]          PRDATA,
  input  logic                 PSLVERR
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t          state_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   owner_q;
  logic [TCW-1:0]  cnt_q;
  logic [31:0]     paddr_q;
  logic [31:0]     pwdata_q;
  logic [3:0]      pstrb_q;
  logic [2:0]      pprot_q;
  logic            pwrite_q;
  logic            psel_q;
  logic            penable_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic [31:0]     rsp_rdata_q;
  logic            rsp_slverr_q;
  logic            rsp_timeout_q;

  logic            gnt_found;
  logic [PW-1:0]   gnt_idx;
  logic [PW-1:0]   cand;
  int              k;

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    k         = 0;
    for (int i = 1; i <= NREQ; i++) begin
      k    = (int'(ptr_q) + i) % NREQ;
      cand = PW'(k);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && gnt_found && !PRESET) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q       <= S_IDLE;
      ptr_q         <= PW'(NREQ - 1);
      owner_q       <= '0;
      cnt_q         <= '0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= '0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_found) begin
            owner_q  <= gnt_idx;
            ptr_q    <= gnt_idx;
            paddr_q  <= req_addr[int'(gnt_idx)*32 +: 32];
            pwdata_q <= req_wdata[int'(gnt_idx)*32 +: 32];
            pprot_q  <= req_prot[int'(gnt_idx)*3 +: 3];
            pwrite_q <= req_write[gnt_idx];
            pstrb_q  <= req_write[gnt_idx] ? req_strb[int'(gnt_idx)*4 +: 4] : 4'h0;
            psel_q   <= 1'b1;
            state_q  <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= S_ACCESS;
        end
        S_ACCESS: begin
          // A completing PREADY takes precedence over the watchdog on the same edge.
          if (PREADY) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= NREQ'(1) << owner_q;
            rsp_rdata_q   <= pwrite_q ? 32'h0 : PRDATA;
            rsp_slverr_q  <= PSLVERR;
            rsp_timeout_q <= 1'b0;
            state_q       <= S_RESP;
          end else if (cnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= NREQ'(1) << owner_q;
            rsp_rdata_q   <= 32'h0;
            rsp_slverr_q  <= 1'b1;
            rsp_timeout_q <= 1'b1;
            state_q       <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          rsp_valid_q   <= '0;
          rsp_rdata_q   <= '0;
          rsp_slverr_q  <= 1'b0;
          rsp_timeout_q <= 1'b0;
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign PADDR       = paddr_q;
  assign PPROT       = pprot_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: two requesters, 8-cycle watchdog.
module tb_apb_master_arbiter;
  localparam int NREQ = 2;
  localparam int TO   = 8;
  localparam int TCW  = 4;

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_write;
  logic [NREQ*32-1:0] req_addr;
  logic [NREQ*32-1:0] req_wdata;
  logic [NREQ*4-1:0] req_strb;
  logic [NREQ*3-1:0] req_prot;
  logic [NREQ-1:0]   rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_slverr;
  logic              rsp_timeout;
  logic [31:0]       PADDR;
  logic [2:0]        PPROT;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [31:0]       PWDATA;
  logic [3:0]        PSTRB;
  logic              PREADY;
  logic [31:0]       PRDATA;
  logic              PSLVERR;

  apb_master_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(TO), .TCW(TCW)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PPROT(PPROT), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic set_req(input int idx, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot);
    req_write[idx]          = wr;
    req_addr[idx*32 +: 32]  = addr;
    req_wdata[idx*32 +: 32] = wdata;
    req_strb[idx*4 +: 4]    = strb;
    req_prot[idx*3 +: 3]    = prot;
  endtask

  // Called in an IDLE cycle; ends in the IDLE cycle after RESP.
  task automatic run_xfer(input string nm, input int idx, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [2:0] prot, input int waits,
                          input logic [31:0] rd, input logic err, input logic to);
    int acc;
    int t0;
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    set_req(idx, wr, addr, wdata, strb, prot);
    req_valid = oh;
    #1;
    check({nm, ".ready"}, 32'(req_ready), 32'(oh));
    check({nm, ".idle_psel"}, 32'(PSEL), 32'd0);
    t0 = cyc;
    tick;
    req_valid = '0;
    PREADY    = 1'b1;
    PRDATA    = 32'hBAD0BAD0;
    #1;
    check({nm, ".setup_sel_en"}, {30'b0, PSEL, PENABLE}, 32'd2);
    check({nm, ".paddr"}, PADDR, addr);
    check({nm, ".pwrite"}, 32'(PWRITE), 32'(wr));
    check({nm, ".pwdata"}, PWDATA, wdata);
    check({nm, ".pstrb"}, 32'(PSTRB), wr ? 32'(strb) : 32'd0);
    check({nm, ".pprot"}, 32'(PPROT), 32'(prot));
    check({nm, ".setup_ready"}, 32'(req_ready), 32'd0);
    acc = to ? TO : waits + 1;
    for (int j = 0; j < acc; j++) begin
      tick;
      PREADY  = !to && (j == waits);
      PSLVERR = !to && err && (j == waits);
      PRDATA  = rd;
      #1;
      check({nm, ".access_sel_en"}, {30'b0, PSEL, PENABLE}, 32'd3);
      check({nm, ".access_paddr"}, PADDR, addr);
    end
    tick;
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    #1;
    check({nm, ".rsp_valid"}, 32'(rsp_valid), 32'(oh));
    check({nm, ".rsp_rdata"}, rsp_rdata, (to || wr) ? 32'd0 : rd);
    check({nm, ".rsp_slverr"}, 32'(rsp_slverr), 32'(err | to));
    check({nm, ".rsp_timeout"}, 32'(rsp_timeout), 32'(to));
    check({nm, ".resp_sel_en"}, {30'b0, PSEL, PENABLE}, 32'd0);
    check({nm, ".latency"}, 32'(cyc - t0), 32'(acc + 2));
    tick;
    #1;
    check({nm, ".post_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({nm, ".post_rsp_flags"}, {rsp_rdata[29:0], rsp_slverr, rsp_timeout}, 32'd0);
    check({nm, ".idle_paddr_hold"}, PADDR, addr);
  endtask

  int exp_g[4] = '{0, 1, 0, 1};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESET    = 1'b1;
    req_valid = 2'b11;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    req_prot  = '0;
    PREADY    = 1'b0;
    PRDATA    = '0;
    PSLVERR   = 1'b0;
    tick;
    tick;
    #1;
    check("rst.psel_en", {30'b0, PSEL, PENABLE}, 32'd0);
    check("rst.req_ready", 32'(req_ready), 32'd0);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.paddr", PADDR, 32'd0);
    check("rst.pwdata_pstrb", PWDATA | 32'(PSTRB), 32'd0);
    check("rst.rsp", {rsp_rdata[29:0], rsp_slverr, rsp_timeout}, 32'd0);
    req_valid = '0;
    PRESET    = 1'b0;
    tick;
    #1;

    run_xfer("wr0", 0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'h0, 0, 32'h0, 1'b0, 1'b0);
    run_xfer("rd1", 1, 1'b0, 32'h20, 32'h0, 4'hA, 3'h2, 3, 32'h12345678, 1'b0, 1'b0);

    set_req(0, 1'b1, 32'h100, 32'hA0A0A0A0, 4'h3, 3'h1);
    set_req(1, 1'b1, 32'h104, 32'hB1B1B1B1, 4'hC, 3'h5);
    PREADY    = 1'b1;
    req_valid = 2'b11;
    #1;
    for (int n = 0; n < 4; n++) begin
      check("fair.grant", 32'(req_ready), 32'(1 << exp_g[n]));
      tick;
      #1;
      check("fair.paddr", PADDR, exp_g[n] == 0 ? 32'h100 : 32'h104);
      tick;
      tick;
      if (n == 3) req_valid = '0;
      #1;
      check("fair.rsp_valid", 32'(rsp_valid), 32'(1 << exp_g[n]));
      tick;
      #1;
    end
    check("fair.no_grant", 32'(req_ready), 32'd0);
    PREADY = 1'b0;

    run_xfer("tmo", 0, 1'b0, 32'h40, 32'h0, 4'hF, 3'h0, 0, 32'hCAFEF00D, 1'b0, 1'b1);
    run_xfer("serr", 1, 1'b1, 32'h44, 32'h0BADF00D, 4'h5, 3'h3, 0, 32'h0, 1'b1, 1'b0);
    run_xfer("edge", 0, 1'b0, 32'h48, 32'h0, 4'hF, 3'h0, 7, 32'h55AA55AA, 1'b0, 1'b0);

    // Last grant was 0, so with both valid requester 1 wins next.
    set_req(0, 1'b0, 32'h200, 32'h0, 4'h0, 3'h0);
    set_req(1, 1'b0, 32'h300, 32'h0, 4'h0, 3'h0);
    req_valid = 2'b11;
    #1;
    check("mrst.grant_before", 32'(req_ready), 32'd2);
    tick;
    tick;
    PREADY = 1'b0;
    #1;
    check("mrst.in_access", {30'b0, PSEL, PENABLE}, 32'd3);
    #2;
    PRESET = 1'b1;
    #1;
    check("mrst.async_sel_en", {30'b0, PSEL, PENABLE}, 32'd0);
    check("mrst.ready", 32'(req_ready), 32'd0);
    check("mrst.rsp_valid", 32'(rsp_valid), 32'd0);
    tick;
    tick;
    PRESET = 1'b0;
    #1;
    check("mrst.first_grant", 32'(req_ready), 32'd1);
    check("mrst.no_rsp", 32'(rsp_valid), 32'd0);
    tick;
    req_valid = '0;
    PREADY    = 1'b1;
    #1;
    check("mrst.setup_paddr", PADDR, 32'h200);
    check("mrst.no_rsp2", 32'(rsp_valid), 32'd0);
    tick;
    #1;
    check("mrst.no_rsp3", 32'(rsp_valid), 32'd0);
    tick;
    #1;
    check("mrst.new_rsp", 32'(rsp_valid), 32'd1);
    tick;
    #1;
    check("mrst.end_rsp", 32'(rsp_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
